reflet_float_seq_cu: RTL and testbench
======================================

// Module: reflet_float_seq_cu
// PURPOSE
//  Parametrised control/sequencing unit for the reflet float CPU. Fetches 16-bit instructions over a
//  req/ack memory handshake, runs stack, jump, call/ret, SET-literal and notification ops against an
//  internal LIFO of STACK_DEPTH floats. Adds conditional jump and multi-halfword SET. Overflow and
//  underflow put the unit into a sticky fault state. The float ALU/register file sits on flt_in/flt_out.
// PARAMETERS
//  FLOAT_SIZE   32   float width; must be a multiple of 16
//  PC_SIZE      16   program counter / instruction byte-address width
//  STACK_DEPTH  64   LIFO entries (>=2); SP_W = $clog2(STACK_DEPTH+1)
// PORTS
//  clk           in   1            clock, rising edge
//  reset         in   1            asynchronous, active-high reset
//  enable        in   1            run request; sampled in IDLE and at the end of EXEC
//  ready         out  1            1 while in IDLE
//  inst_addr     out  PC_SIZE      byte address of the halfword being fetched
//  inst_req      out  1            fetch request; held until inst_ack
//  inst_ack      in   1            fetch data valid this cycle
//  inst_data     in   16           fetched halfword
//  instruction   out  16           current instruction; opcode = instruction[14:9] (OPP_* from reflet_fpu.vh)
//  cmp_flag      in   1            condition for OPP_JIF
//  ctrl_flag     in   3            notification code
//  notification  out  3            ctrl_flag during NOTIF EXEC, else 0
//  flt_in        in   FLOAT_SIZE   register operand: push data, or jump/call target
//  flt_out       out  FLOAT_SIZE   result for the register file
//  flt_out_we    out  1            1-cycle strobe when flt_out is updated
//  sp            out  SP_W         number of occupied stack entries
//  fault         out  2            01 = overflow, 10 = underflow; sticky until reset
// BEHAVIOUR
//  Reset (async, takes effect immediately, including mid-fetch):
//   - state=IDLE; pc, instruction, flt_out, sp, fault = 0
//   - inst_req, flt_out_we, notification = 0; ready = 1
//  States: IDLE, FETCH, EXEC, SETLD, FAULT
//   - IDLE:  enable=1 -> FETCH
//   - FETCH: inst_addr=pc, inst_req=1
//            on inst_ack: instruction<=inst_data, pc<=pc+2 (wraps mod 2^PC_SIZE)
//            opcode OPP_SET -> SETLD, else -> EXEC
//            enable is ignored while waiting; the fetch always completes
//   - EXEC (1 cycle), then FETCH if enable=1, else IDLE:
//     NOP: no effect
//     PUSH: mem[sp]<=flt_in, sp+1
//     POP: flt_out<=mem[sp-1], sp-1, flt_out_we
//     MOV: flt_out<=flt_in, flt_out_we
//     JMP: pc<={flt_in[PC_SIZE-1:1],1'b0}
//     JIF: as JMP if cmp_flag=1, else no effect
//     CALL: mem[sp]<=zero-extended pc (return address), sp+1, pc<=target
//     RET: pc<=mem[sp-1][PC_SIZE-1:0] with bit0 cleared, sp-1
//     NOTIF: notification=ctrl_flag for this cycle only
//     other opcodes: treated as NOP
//   - SETLD: fetches N=FLOAT_SIZE/16 further halfwords using the same req/ack rule, pc+=2 each
//            halfword k fills flt_out[16k+15:16k] (little-endian)
//            after the Nth ack: flt_out_we pulses for 1 cycle -> FETCH/IDLE per enable
//   - FAULT: entered from EXEC on PUSH/CALL with sp==STACK_DEPTH (fault=01) or POP/RET with sp==0
//            (fault=10); the offending op has no side effects (no write, sp/pc/flt_out unchanged)
//            inst_req=0, ready=0; exit only by reset
//  Stack: single-port register array, write in EXEC only; LIFO with no wrap; sp saturates by faulting
//  Outputs are registered except ready, inst_addr, inst_req and notification (decoded from state/pc)
// TESTING
//  1. enable=1, NOP,NOP, ack 2 cycles after req -> inst_addr 0 then 2; inst_req held until ack; pc=4
//  2. PUSH A=0x3F800000, PUSH B=0x40000000, POP -> flt_out=0x40000000, flt_out_we 1 cycle, sp=1
//  3. STACK_DEPTH=4, 5x PUSH -> 5th push: fault=01, sp=4, mem unchanged, inst_req=0
//     POP on empty stack after reset -> fault=10
//  4. SET at pc 0 followed by 0x0000,0x4049 -> flt_out=0x40490000, single we pulse, next fetch at 6
//  5. CALL at pc 0x10 with flt_in=0x101 -> pc=0x100, mem[0]=0x12; RET -> pc=0x12, sp=0
//     JIF with cmp_flag=0 falls through; JIF with cmp_flag=1 jumps
//  6. Assert reset while inst_req=1 and ack pending -> inst_req=0 in the same cycle, all outputs at
//     reset values; after release, fetch restarts at 0

Source files
------------

// File: rtl/reflet_float_seq_cu_if.sv
// Instruction fetch bus for the reflet float sequencing unit.
// The control unit is the master: it presents a halfword byte address and
// holds a request until the memory answers with an acknowledge and data.
//   inst_addr  master->slave  byte address of the halfword being fetched
//   inst_req   master->slave  fetch request, held until inst_ack
//   inst_ack   slave->master  inst_data is valid this cycle
//   inst_data  slave->master  fetched 16-bit halfword
interface reflet_float_seq_cu_if #(
  parameter int PC_SIZE = 16
);
  logic [PC_SIZE-1:0] inst_addr;
  logic               inst_req;
  logic               inst_ack;
  logic [15:0]        inst_data;

  modport master (
    output inst_addr,
    output inst_req,
    input  inst_ack,
    input  inst_data
  );

  modport slave (
    input  inst_addr,
    input  inst_req,
    output inst_ack,
    output inst_data
  );
endinterface

// File: rtl/reflet_float_seq_cu.sv
// Control/sequencing unit of the reflet float CPU.
// Fetches 16-bit instructions over a req/ack bus and executes stack, jump,
// conditional jump, call/ret, multi-halfword SET and notification operations
// against an internal LIFO of floats. Stack overflow/underflow parks the unit
// in a sticky FAULT state that only reset leaves.
// Ports:
//   clk, reset    rising-edge clock, asynchronous active-high reset
//   enable        run request, sampled in IDLE and at the end of EXEC
//   ready         high while idle
//   bus           instruction fetch bus (master side)
//   instruction   latched current instruction, opcode in bits [14:9]
//   cmp_flag      condition for the conditional jump
//   ctrl_flag     code forwarded to notification during a NOTIF op
//   notification  ctrl_flag while a NOTIF op executes, else 0
//   flt_in        register operand: push data or jump/call target
//   flt_out       result towards the register file, flt_out_we strobes it
//   sp            number of occupied stack entries
//   fault         01 overflow, 10 underflow, sticky until reset
module reflet_float_seq_cu #(
  parameter  int FLOAT_SIZE  = 32,
  parameter  int PC_SIZE     = 16,
  parameter  int STACK_DEPTH = 64,
  localparam int SP_W        = $clog2(STACK_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  output logic                  ready,
  reflet_float_seq_cu_if.master bus,
  output logic [15:0]           instruction,
  input  logic                  cmp_flag,
  input  logic [2:0]            ctrl_flag,
  output logic [2:0]            notification,
  input  logic [FLOAT_SIZE-1:0] flt_in,
  output logic [FLOAT_SIZE-1:0] flt_out,
  output logic                  flt_out_we,
  output logic [SP_W-1:0]       sp,
  output logic [1:0]            fault
);

  localparam int IDX_W  = $clog2(STACK_DEPTH);
  localparam int N_HALF = FLOAT_SIZE / 16;
  localparam int HW_W   = (N_HALF > 1) ? $clog2(N_HALF) : 1;

  // Opcode map, kept in step with the FPU opcode header
  localparam logic [5:0] OPP_NOP   = 6'd0;
  localparam logic [5:0] OPP_PUSH  = 6'd1;
  localparam logic [5:0] OPP_POP   = 6'd2;
  localparam logic [5:0] OPP_MOV   = 6'd3;
  localparam logic [5:0] OPP_JMP   = 6'd4;
  localparam logic [5:0] OPP_JIF   = 6'd5;
  localparam logic [5:0] OPP_CALL  = 6'd6;
  localparam logic [5:0] OPP_RET   = 6'd7;
  localparam logic [5:0] OPP_NOTIF = 6'd8;
  localparam logic [5:0] OPP_SET   = 6'd9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_SETLD,
    ST_FAULT
  } state_t;

  state_t                state;
  logic [PC_SIZE-1:0]    pc;
  logic [HW_W-1:0]       half_idx;
  logic [FLOAT_SIZE-1:0] mem [STACK_DEPTH];

  logic [5:0]            opcode;
  logic [SP_W-1:0]       sp_dec;
  logic [IDX_W-1:0]      top_idx;
  logic [IDX_W-1:0]      push_idx;
  logic                  stack_full;
  logic                  stack_empty;
  logic [FLOAT_SIZE-1:0] top_val;
  logic [PC_SIZE-1:0]    target;
  logic [PC_SIZE-1:0]    ret_addr;
  logic                  push_we;
  logic [FLOAT_SIZE-1:0] push_data;

  assign opcode      = instruction[14:9];
  assign sp_dec      = sp - SP_W'(1);
  assign top_idx     = sp_dec[IDX_W-1:0];
  assign push_idx    = sp[IDX_W-1:0];
  assign stack_full  = (sp == SP_W'(STACK_DEPTH));
  assign stack_empty = (sp == '0);
  assign top_val     = mem[top_idx];
  // Instructions are halfword aligned, so jump targets drop bit 0
  assign target      = {flt_in[PC_SIZE-1:1], 1'b0};
  assign ret_addr    = {top_val[PC_SIZE-1:1], 1'b0};

  assign ready           = (state == ST_IDLE);
  assign bus.inst_req    = (state == ST_FETCH) || (state == ST_SETLD);
  assign bus.inst_addr   = pc;
  assign notification    = ((state == ST_EXEC) && (opcode == OPP_NOTIF)) ? ctrl_flag : 3'b000;

  // Stack write port; a push that would overflow writes nothing
  always_comb begin
    push_we   = 1'b0;
    push_data = '0;
    if ((state == ST_EXEC) && !stack_full) begin
      if (opcode == OPP_PUSH) begin
        push_we   = 1'b1;
        push_data = flt_in;
      end else if (opcode == OPP_CALL) begin
        push_we   = 1'b1;
        push_data = FLOAT_SIZE'(pc);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_we) begin
      mem[push_idx] <= push_data;
    end
  end

  // Sequencer: fetch, decode into EXEC or SETLD, execute, then refetch or idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      pc          <= '0;
      instruction <= '0;
      flt_out     <= '0;
      flt_out_we  <= 1'b0;
      sp          <= '0;
      fault       <= 2'b00;
      half_idx    <= '0;
    end else begin
      flt_out_we <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (enable) begin
            state <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (bus.inst_ack) begin
            instruction <= bus.inst_data;
            pc          <= pc + PC_SIZE'(2);
            half_idx    <= '0;
            state       <= (bus.inst_data[14:9] == OPP_SET) ? ST_SETLD : ST_EXEC;
          end
        end
        ST_EXEC: begin
          state <= enable ? ST_FETCH : ST_IDLE;
          case (opcode)
            OPP_PUSH: begin
              if (stack_full) begin
                state <= ST_FAULT;
                fault <= 2'b01;
              end else begin
                sp <= sp + SP_W'(1);
              end
            end
            OPP_POP: begin
              if (stack_empty) begin
                state <= ST_FAULT;
                fault <= 2'b10;
              end else begin
                flt_out    <= top_val;
                flt_out_we <= 1'b1;
                sp         <= sp_dec;
              end
            end
            OPP_MOV: begin
              flt_out    <= flt_in;
              flt_out_we <= 1'b1;
            end
            OPP_JMP: begin
              pc <= target;
            end
            OPP_JIF: begin
              if (cmp_flag) begin
                pc <= target;
              end
            end
            OPP_CALL: begin
              if (stack_full) begin
                state <= ST_FAULT;
                fault <= 2'b01;
              end else begin
                sp <= sp + SP_W'(1);
                pc <= target;
              end
            end
            OPP_RET: begin
              if (stack_empty) begin
                state <= ST_FAULT;
                fault <= 2'b10;
              end else begin
                pc <= ret_addr;
                sp <= sp_dec;
              end
            end
            default: begin
            end
          endcase
        end
        ST_SETLD: begin
          // Literal halfwords arrive least significant first
          if (bus.inst_ack) begin
            flt_out[16*half_idx +: 16] <= bus.inst_data;
            pc <= pc + PC_SIZE'(2);
            if (half_idx == HW_W'(N_HALF - 1)) begin
              flt_out_we <= 1'b1;
              state      <= enable ? ST_FETCH : ST_IDLE;
            end else begin
              half_idx <= half_idx + HW_W'(1);
            end
          end
        end
        ST_FAULT: begin
          state <= ST_FAULT;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reflet_float_seq_cu.sv
// Testbench for reflet_float_seq_cu: a small program memory answers fetches
// after a programmable latency while directed programs exercise fetch, stack,
// SET literal, jumps, call/ret, notifications, faults and mid-fetch reset.
module tb_reflet_float_seq_cu;

  localparam int FS  = 32;
  localparam int PS  = 16;
  localparam int SD  = 4;
  localparam int SPW = $clog2(SD + 1);

  localparam logic [15:0] I_NOP   = 16'h0000;
  localparam logic [15:0] I_PUSH  = 16'h0200;
  localparam logic [15:0] I_POP   = 16'h0400;
  localparam logic [15:0] I_MOV   = 16'h0600;
  localparam logic [15:0] I_JMP   = 16'h0800;
  localparam logic [15:0] I_JIF   = 16'h0A00;
  localparam logic [15:0] I_CALL  = 16'h0C00;
  localparam logic [15:0] I_RET   = 16'h0E00;
  localparam logic [15:0] I_NOTIF = 16'h1000;
  localparam logic [15:0] I_SET   = 16'h1200;

  logic           clk = 1'b0;
  logic           reset;
  logic           enable;
  logic           ready;
  logic [15:0]    instruction;
  logic           cmp_flag;
  logic [2:0]     ctrl_flag;
  logic [2:0]     notification;
  logic [FS-1:0]  flt_in;
  logic [FS-1:0]  flt_out;
  logic           flt_out_we;
  logic [SPW-1:0] sp;
  logic [1:0]     fault;

  logic [15:0] prog [256];
  int          ack_lat;
  int          check_count;
  int          pass_count;
  int          we_count;

  reflet_float_seq_cu_if #(.PC_SIZE(PS)) bus ();

  reflet_float_seq_cu #(
    .FLOAT_SIZE (FS),
    .PC_SIZE    (PS),
    .STACK_DEPTH(SD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .ready       (ready),
    .bus         (bus),
    .instruction (instruction),
    .cmp_flag    (cmp_flag),
    .ctrl_flag   (ctrl_flag),
    .notification(notification),
    .flt_in      (flt_in),
    .flt_out     (flt_out),
    .flt_out_we  (flt_out_we),
    .sp          (sp),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  // Count write strobes so a SET can be shown to pulse exactly once
  always @(negedge clk) begin
    if (flt_out_we) we_count++;
  end

  // Program memory: acknowledges a held request after ack_lat waiting cycles
  initial begin
    int cnt;
    cnt = 0;
    bus.inst_ack  = 1'b0;
    bus.inst_data = 16'h0000;
    forever begin
      @(negedge clk);
      if (bus.inst_req && !bus.inst_ack && !reset) begin
        if (cnt >= ack_lat) begin
          bus.inst_ack  = 1'b1;
          bus.inst_data = prog[bus.inst_addr[8:1]];
          cnt = 0;
        end else begin
          cnt++;
        end
      end else begin
        bus.inst_ack = 1'b0;
        cnt = 0;
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got === exp) pass_count++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  task automatic clearProg();
    for (int i = 0; i < 256; i++) prog[i] = I_NOP;
  endtask

  task automatic applyReset();
    enable    = 1'b0;
    flt_in    = '0;
    cmp_flag  = 1'b0;
    ctrl_flag = 3'd0;
    reset     = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Returns at the negedge+1 of the acknowledged fetch, before it is consumed
  task automatic waitAck(output logic [15:0] addr, output int waits);
    bit found;
    found = 1'b0;
    waits = 0;
    addr  = '0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      #1;
      if (bus.inst_req && bus.inst_ack) begin
        found = 1'b1;
        addr  = bus.inst_addr;
      end else if (bus.inst_req) begin
        waits++;
      end
    end
    if (!found) checkOutput("ack_timeout", 32'd0, 32'd1);
  endtask

  // Fetch one non-SET instruction, drive its operands and run it through EXEC
  task automatic applyStimulus(input logic [31:0] fin, input logic cmp, input logic [2:0] flag,
                               output logic [15:0] addr, output logic [2:0] notif_seen);
    int w;
    waitAck(addr, w);
    flt_in    = fin;
    cmp_flag  = cmp;
    ctrl_flag = flag;
    @(posedge clk);
    #1;
    notif_seen = notification;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] a;
    logic [2:0]  nf;
    int          w;
    int          we_before;

    check_count = 0;
    pass_count  = 0;
    we_count    = 0;
    ack_lat     = 1;
    clearProg();

    // Reset values
    enable = 1'b0; flt_in = '0; cmp_flag = 1'b0; ctrl_flag = 3'd0;
    reset = 1'b1;
    #12;
    checkOutput("rst_ready", ready, 1);
    checkOutput("rst_req", bus.inst_req, 0);
    checkOutput("rst_sp", sp, 0);
    checkOutput("rst_fault", fault, 0);
    checkOutput("rst_flt_out", flt_out, 0);
    checkOutput("rst_we", flt_out_we, 0);
    checkOutput("rst_instr", instruction, 0);
    checkOutput("rst_notif", notification, 0);

    // Fetch sequencing with a two-cycle memory, enable ignored mid-fetch
    clearProg();
    ack_lat = 2;
    applyReset();
    enable = 1'b1;
    waitAck(a, w);
    checkOutput("t1_addr0", a, 32'h0);
    checkOutput("t1_held0", w, 2);
    waitAck(a, w);
    checkOutput("t1_addr1", a, 32'h2);
    checkOutput("t1_held1", w, 2);
    enable = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("t1_idle_ready", ready, 1);
    checkOutput("t1_idle_req", bus.inst_req, 0);
    enable = 1'b1;
    waitAck(a, w);
    checkOutput("t1_pc4", a, 32'h4);

    // Push, push, pop, mov
    clearProg();
    ack_lat = 1;
    prog[0] = I_PUSH; prog[1] = I_PUSH; prog[2] = I_POP; prog[3] = I_MOV;
    applyReset();
    enable = 1'b1;
    applyStimulus(32'h3F800000, 1'b0, 3'd0, a, nf);
    checkOutput("t2_sp1", sp, 1);
    checkOutput("t2_instr", instruction, 32'h0200);
    applyStimulus(32'h40000000, 1'b0, 3'd0, a, nf);
    checkOutput("t2_sp2", sp, 2);
    applyStimulus(32'hDEADBEEF, 1'b0, 3'd0, a, nf);
    checkOutput("t2_pop_addr", a, 32'h4);
    checkOutput("t2_pop_val", flt_out, 32'h40000000);
    checkOutput("t2_pop_we", flt_out_we, 1);
    checkOutput("t2_pop_sp", sp, 1);
    @(posedge clk);
    #1;
    checkOutput("t2_we_drop", flt_out_we, 0);
    applyStimulus(32'h12345678, 1'b0, 3'd0, a, nf);
    checkOutput("t2_mov_val", flt_out, 32'h12345678);
    checkOutput("t2_mov_we", flt_out_we, 1);

    // Overflow on the fifth push into a four-entry stack
    clearProg();
    for (int i = 0; i < 5; i++) prog[i] = I_PUSH;
    applyReset();
    enable = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(32'h100 + i, 1'b0, 3'd0, a, nf);
    checkOutput("t3_full_sp", sp, 4);
    applyStimulus(32'hFFFF0000, 1'b0, 3'd0, a, nf);
    checkOutput("t3_ovf_fault", fault, 2'b01);
    checkOutput("t3_ovf_sp", sp, 4);
    checkOutput("t3_ovf_req", bus.inst_req, 0);
    checkOutput("t3_ovf_ready", ready, 0);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("t3_ovf_sticky", fault, 2'b01);
    checkOutput("t3_ovf_req_late", bus.inst_req, 0);

    // Underflow on a pop from an empty stack
    clearProg();
    prog[0] = I_POP;
    applyReset();
    checkOutput("t3_fault_cleared", fault, 0);
    enable = 1'b1;
    applyStimulus(32'h0, 1'b0, 3'd0, a, nf);
    checkOutput("t3_udf_fault", fault, 2'b10);
    checkOutput("t3_udf_sp", sp, 0);
    checkOutput("t3_udf_flt_out", flt_out, 0);
    checkOutput("t3_udf_we", flt_out_we, 0);

    // SET with a two-halfword little-endian literal
    clearProg();
    prog[0] = I_SET; prog[1] = 16'h0000; prog[2] = 16'h4049;
    applyReset();
    enable = 1'b1;
    we_before = we_count;
    waitAck(a, w);
    checkOutput("t4_set_addr", a, 32'h0);
    waitAck(a, w);
    checkOutput("t4_lit0_addr", a, 32'h2);
    waitAck(a, w);
    checkOutput("t4_lit1_addr", a, 32'h4);
    @(posedge clk);
    #1;
    checkOutput("t4_value", flt_out, 32'h40490000);
    checkOutput("t4_we", flt_out_we, 1);
    @(posedge clk);
    #1;
    checkOutput("t4_we_drop", flt_out_we, 0);
    checkOutput("t4_we_pulses", we_count - we_before, 1);
    waitAck(a, w);
    checkOutput("t4_next_addr", a, 32'h6);

    // Jumps, call/ret and notification
    clearProg();
    prog[0]    = I_JMP;
    prog[8]    = I_CALL;
    prog[9]    = I_JIF;
    prog[10]   = I_JIF;
    prog[8'h20] = I_CALL;
    prog[8'h40] = I_POP;
    prog[8'h41] = I_NOTIF;
    prog[8'h80] = I_RET;
    applyReset();
    enable = 1'b1;
    applyStimulus(32'h11, 1'b0, 3'd0, a, nf);
    applyStimulus(32'h101, 1'b0, 3'd0, a, nf);
    checkOutput("t5_call_addr", a, 32'h10);
    checkOutput("t5_call_sp", sp, 1);
    applyStimulus(32'h0, 1'b0, 3'd0, a, nf);
    checkOutput("t5_target_addr", a, 32'h100);
    checkOutput("t5_ret_sp", sp, 0);
    applyStimulus(32'h40, 1'b0, 3'd0, a, nf);
    checkOutput("t5_ret_addr", a, 32'h12);
    applyStimulus(32'h40, 1'b1, 3'd0, a, nf);
    checkOutput("t5_jif_fall", a, 32'h14);
    applyStimulus(32'h81, 1'b0, 3'd0, a, nf);
    checkOutput("t5_jif_taken", a, 32'h40);
    checkOutput("t5_call2_sp", sp, 1);
    applyStimulus(32'h0, 1'b0, 3'd0, a, nf);
    checkOutput("t5_pop_addr", a, 32'h80);
    checkOutput("t5_retaddr_val", flt_out, 32'h42);
    checkOutput("t5_pop_sp", sp, 0);
    applyStimulus(32'h0, 1'b0, 3'd5, a, nf);
    checkOutput("t5_notif_addr", a, 32'h82);
    checkOutput("t5_notif_exec", nf, 3'd5);
    checkOutput("t5_notif_after", notification, 3'd0);
    waitAck(a, w);
    checkOutput("t5_after_notif", a, 32'h84);

    // Reset asserted while a fetch is pending
    clearProg();
    prog[0] = I_PUSH; prog[1] = I_MOV;
    ack_lat = 3;
    applyReset();
    enable = 1'b1;
    applyStimulus(32'hAAAA0000, 1'b0, 3'd0, a, nf);
    applyStimulus(32'h55555555, 1'b0, 3'd0, a, nf);
    checkOutput("t6_pre_flt_out", flt_out, 32'h55555555);
    @(negedge clk);
    #2;
    checkOutput("t6_pending_req", bus.inst_req, 1);
    checkOutput("t6_pending_ack", bus.inst_ack, 0);
    reset = 1'b1;
    #1;
    checkOutput("t6_req", bus.inst_req, 0);
    checkOutput("t6_ready", ready, 1);
    checkOutput("t6_sp", sp, 0);
    checkOutput("t6_flt_out", flt_out, 0);
    checkOutput("t6_instr", instruction, 0);
    checkOutput("t6_addr", bus.inst_addr, 0);
    checkOutput("t6_fault", fault, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    waitAck(a, w);
    checkOutput("t6_restart_addr", a, 32'h0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
